hpdmc_busif_mp: RTL
===================

// Module: hpdmc_busif_mp
// PURPOSE
//  Multi-port FML front end for HPDMC: round-robin arbitration of NPORTS FML masters onto one
//  mgmt command port, with up to OUTSTANDING accepted commands in flight. A tag FIFO records the
//  granted port per accepted command, so each data_ack is routed to the correct master's fml_ack.
//  Sits between the FML crossbar/masters and the HPDMC mgmt/datactl path.
// PARAMETERS
//  sdram_depth  26  byte address width of each FML port
//  nports       4   number of FML master ports (1..8)
//  outstanding  2   tag FIFO depth = max accepted-but-unacked commands (power of two, >=1)
//  (localparams: pw = max(1,clog2(nports)), ow = clog2(outstanding)+1)
// PORTS
//  sys_clk       in   1                     system clock
//  sdram_rst_n   in   1                     asynchronous reset, active low
//  fml_adr       in   nports*sdram_depth    port i address at [i*sdram_depth +: sdram_depth]
//  fml_stb       in   nports                per-port request strobe
//  fml_we        in   nports                per-port write enable
//  fml_ack       out  nports                per-port ack (one-hot or zero)
//  mgmt_stb      out  1                     command strobe to mgmt
//  mgmt_we       out  1                     command direction
//  mgmt_address  out  sdram_depth-2         command address in 32-bit words (selected fml_adr[sdram_depth-1:2])
//  mgmt_ack      in   1                     mgmt accepted command
//  data_ack      in   1                     data phase of oldest accepted command complete
//  err_underflow out  1                     sticky: data_ack seen with tag FIFO empty
// BEHAVIOUR
//  Reset (sdram_rst_n=0, async): lock=0, sel=0, rr=0, pending=0, FIFO empty (count=0),
//   err_underflow=0; hence mgmt_stb=0, fml_ack=0. mgmt_we/mgmt_address follow sel=0.
//  Eligible port i: fml_stb[i] & ~pending[i].
//  Arbitration (registered): when lock=0 and any port eligible, at next edge sel<=first eligible
//   port searching rr, rr+1, ... (mod nports); lock<=1. Grant-to-strobe latency = 1 cycle.
//  mgmt_stb = lock & fml_stb[sel] & ~full (comb.); mgmt_we=fml_we[sel]; mgmt_address from port sel.
//  Selection is held while lock=1; no re-arbitration until release.
//  Release: on mgmt_ack & mgmt_stb -> lock<=0, rr<=sel+1 (wrap at nports), pending[sel]<=1,
//   push sel into tag FIFO. mgmt_ack while mgmt_stb=0 is ignored.
//  If fml_stb[sel] drops while lock=1 and before mgmt_ack (master protocol violation):
//   lock<=0, no push, rr unchanged.
//  full = (count==outstanding): mgmt_stb forced 0, lock held; resumes once a pop occurs.
//  fml_ack[i] = data_ack & ~empty & (head==i) (comb., zero-cycle like single-port version).
//  On data_ack & ~empty: pop head, pending[head]<=0. On data_ack & empty: no pop,
//   err_underflow<=1 (cleared only by reset).
//  Push and pop same cycle: count unchanged, head/tail both advance; legal when full
//   (pop frees slot; mgmt_stb is already 0 when full, so push cannot coincide with full).
//  Pointers wrap mod outstanding; count width ow, never exceeds outstanding.
//  A port is never issued twice before its data_ack (pending mask), so order per port is kept;
//   across ports, fml_ack order equals mgmt_ack order.
//  nports=1: arbiter degenerates, sel=0; behaviour equals the single-port interface plus 1-cycle
//   grant latency and FIFO tracking.
//  Reset mid-operation: all in-flight tags discarded; no fml_ack issued for them.
// TESTING
//  Single: port0 stb, adr=0x0000104 we=0 -> mgmt_stb 1 cycle later, mgmt_address=0x41; mgmt_ack,
//   data_ack 3 cycles later -> fml_ack=4'b0001 for exactly that cycle.
//  Round robin: ports 0..3 all stb, mgmt_ack each grant cycle -> grant order 0,1,2,3; after
//   data_acks, re-request all -> order continues 0,1,2,3 (rr wrapped from 3 to 0).
//  Outstanding limit (outstanding=2): 3 ports requesting, no data_ack -> 2 mgmt_acks, then
//   mgmt_stb=0 while full; one data_ack -> fml_ack to first granted port, third issued next cycle.
//  Simultaneous: data_ack and mgmt_ack same cycle with count=1 -> count stays 1, head port acked,
//   new tag queued; subsequent data_ack acks the new port.
//  Underflow: data_ack with empty FIFO -> fml_ack=0, err_underflow=1 and stays 1 until reset.
//  Async reset with 2 outstanding -> outputs 0 immediately, no fml_ack after reset release.

Source files
------------

// File: rtl/hpdmc_busif_mp_if.sv
//------------------------------------------------------------------------------
// Module      : hpdmc_busif_mp_if
// Description : FML master ports and HPDMC mgmt/data handshake bundle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hpdmc_busif_mp_if #(
    parameter int SDRAM_DEPTH = 26,
    parameter int NPORTS      = 4
);
    logic [NPORTS*SDRAM_DEPTH-1:0] fml_adr;
    logic [NPORTS-1:0]             fml_stb;
    logic [NPORTS-1:0]             fml_we;
    logic [NPORTS-1:0]             fml_ack;
    logic                          mgmt_stb;
    logic                          mgmt_we;
    logic [SDRAM_DEPTH-3:0]        mgmt_address;
    logic                          mgmt_ack;
    logic                          data_ack;

    modport slave (
        input  fml_adr, fml_stb, fml_we, mgmt_ack, data_ack,
        output fml_ack, mgmt_stb, mgmt_we, mgmt_address
    );

    modport master (
        output fml_adr, fml_stb, fml_we, mgmt_ack, data_ack,
        input  fml_ack, mgmt_stb, mgmt_we, mgmt_address
    );
endinterface

`default_nettype wire

// File: rtl/hpdmc_busif_mp.sv
//------------------------------------------------------------------------------
// Module      : hpdmc_busif_mp
// Description : Round-robin multi-port FML front end with tag FIFO ack routing.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hpdmc_busif_mp #(
    parameter int SDRAM_DEPTH = 26,
    parameter int NPORTS      = 4,
    parameter int OUTSTANDING = 2
) (
    input  wire logic        sys_clk,
    input  wire logic        sdram_rst_n,
    hpdmc_busif_mp_if.slave  bus,
    output logic             err_underflow
);
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int OW = $clog2(OUTSTANDING) + 1;
    localparam int AW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [PW-1:0]       r_sel, r_rr, w_pick, w_sel_inc;
    logic [NPORTS-1:0]   r_pending, w_elig;
    logic [PW-1:0]       r_tags [OUTSTANDING];
    logic [AW-1:0]       r_head, r_tail;
    logic [OW-1:0]       r_count;
    logic                r_err;
    logic                w_found, w_load_sel, w_full, w_empty, w_push, w_pop, w_sel_stb;
    int                  w_idx;
    logic [SDRAM_DEPTH-3:0] w_word [NPORTS];
    logic [2*NPORTS-1:0]    w_adr_lsb;
    logic                   w_unused_adr_lsb;

    generate
        for (genvar i = 0; i < NPORTS; i++) begin : g_port
            assign w_word[i]           = bus.fml_adr[i*SDRAM_DEPTH+2 +: SDRAM_DEPTH-2];
            assign w_adr_lsb[2*i +: 2] = bus.fml_adr[i*SDRAM_DEPTH +: 2];
            assign bus.fml_ack[i]      = w_pop & (r_tags[r_head] == PW'(i));
        end
    endgenerate
    assign w_unused_adr_lsb = ^w_adr_lsb;

    assign w_elig    = bus.fml_stb & ~r_pending;
    assign w_sel_stb = bus.fml_stb[r_sel];
    assign w_full    = (r_count == OW'(OUTSTANDING));
    assign w_empty   = (r_count == '0);
    assign w_sel_inc = (r_sel == PW'(NPORTS-1)) ? '0 : r_sel + 1'b1;

    assign bus.mgmt_stb     = (r_state == S_LOCK) & w_sel_stb & ~w_full;
    assign bus.mgmt_we      = bus.fml_we[r_sel];
    assign bus.mgmt_address = w_word[r_sel];
    assign w_push           = bus.mgmt_stb & bus.mgmt_ack;
    assign w_pop            = bus.data_ack & ~w_empty;
    assign err_underflow    = r_err;

    // First eligible port at or after the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = 0; k < NPORTS; k++) begin
            w_idx = (int'(r_rr) + k) % NPORTS;
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_pick  = PW'(w_idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_sel  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_LOCK;
                    w_load_sel  = 1'b1;
                end
            end
            S_LOCK: begin
                // A master dropping its strobe before mgmt_ack releases the lock without a push.
                if (w_push || !w_sel_stb)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_rr      <= '0;
            r_pending <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
            for (int j = 0; j < OUTSTANDING; j++)
                r_tags[j] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_sel)
                r_sel <= w_pick;
            if (w_pop) begin
                r_pending[r_tags[r_head]] <= 1'b0;
                r_head <= (r_head == AW'(OUTSTANDING-1)) ? '0 : r_head + 1'b1;
            end
            if (w_push) begin
                r_rr             <= w_sel_inc;
                r_pending[r_sel] <= 1'b1;
                r_tags[r_tail]   <= r_sel;
                r_tail <= (r_tail == AW'(OUTSTANDING-1)) ? '0 : r_tail + 1'b1;
            end
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
            if (bus.data_ack && w_empty)
                r_err <= 1'b1;
        end
    end
endmodule

`default_nettype wire
